// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the mux_rr_arbiter slice.
// Grant-state encoding and the width of the optional per-requester packet counters.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam int GCNT_W = 16;

    // Tie-break: ptr holds the requester served last, so the other one wins.
    function automatic arb_state_e tie_grant(input logic ptr);
        return ptr ? GNT0 : GNT1;
    endfunction

endpackage : mux_arb_pkg

// File: rtl/MUX_2_to_1.sv
// Plain 2:1 mux of two size-bit words; select_i=1 picks data1_i.
module MUX_2_to_1 #(
    parameter int size = 32
) (
    input  logic [size-1:0] data0_i,
    input  logic [size-1:0] data1_i,
    input  logic            select_i,
    output logic [size-1:0] data_o
);

    assign data_o = select_i ? data1_i : data0_i;

endmodule : MUX_2_to_1

// File: rtl/mux_arb_out_reg.sv
// One-entry registered output stage: load a new beat, hold it under backpressure,
// or drain it when the consumer takes it. A load wins over a drain (no bubble).
module mux_arb_out_reg #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [size-1:0] data_in,
    input  logic            last_in,
    input  logic            src_in,
    input  logic            ready,
    output logic [size-1:0] data,
    output logic            valid,
    output logic            last,
    output logic            src
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
            src   <= 1'b0;
        end else if (load) begin
            data  <= data_in;
            valid <= 1'b1;
            last  <= last_in;
            src   <= src_in;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule : mux_arb_out_reg

// File: rtl/mux_rr_arbiter.sv
// Packet-locked round-robin arbiter for two requesters sharing one registered 2:1 mux path.
// Optional per-requester completed-packet counters: define MUX_RR_ARBITER_GRANT_CNT_EN.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int size = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [size-1:0]     data0_i,
    input  logic                valid0_i,
    input  logic                last0_i,
    output logic                ready0_o,
    input  logic [size-1:0]     data1_i,
    input  logic                valid1_i,
    input  logic                last1_i,
    output logic                ready1_o,
    output logic [size-1:0]     data_o,
    output logic                valid_o,
    output logic                last_o,
    output logic                src_o,
    input  logic                ready_i,
`ifdef MUX_RR_ARBITER_GRANT_CNT_EN
    output logic [GCNT_W-1:0]   gcnt0_o,
    output logic [GCNT_W-1:0]   gcnt1_o,
`endif
    output logic                select_o
);

    arb_state_e      state;
    arb_state_e      state_nxt;
    logic            ptr;
    logic            ptr_nxt;
    logic            sel_q;
    logic            space;
    logic            accept;
    logic [size-1:0] mux_data;
    logic            mux_last;

    // The output stage can take a beat when empty or when it drains this cycle.
    assign space = !valid_o || ready_i;

    // In IDLE the select keeps its last value so the mux never swings to an unselected source.
    assign select_o = (state == GNT1) || ((state == IDLE) && sel_q);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        ready0_o  = 1'b0;
        ready1_o  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (valid0_i && valid1_i) begin
                    state_nxt = tie_grant(ptr);
                end else if (valid0_i) begin
                    state_nxt = GNT0;
                end else if (valid1_i) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                ready0_o = space;
                accept   = valid0_i && space;
                if (accept && last0_i) begin
                    state_nxt = IDLE;
                    ptr_nxt   = 1'b0;
                end
            end
            GNT1: begin
                ready1_o = space;
                accept   = valid1_i && space;
                if (accept && last1_i) begin
                    state_nxt = IDLE;
                    ptr_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            ptr   <= 1'b1;
            sel_q <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel_q <= select_o;
        end
    end

    MUX_2_to_1 #(.size(size)) u_data_mux (
        .data0_i  (data0_i),
        .data1_i  (data1_i),
        .select_i (select_o),
        .data_o   (mux_data)
    );

    MUX_2_to_1 #(.size(1)) u_last_mux (
        .data0_i  (last0_i),
        .data1_i  (last1_i),
        .select_i (select_o),
        .data_o   (mux_last)
    );

    mux_arb_out_reg #(.size(size)) u_out_reg (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .load    (accept),
        .data_in (mux_data),
        .last_in (mux_last),
        .src_in  (select_o),
        .ready   (ready_i),
        .data    (data_o),
        .valid   (valid_o),
        .last    (last_o),
        .src     (src_o)
    );

`ifdef MUX_RR_ARBITER_GRANT_CNT_EN
    logic pkt_done;

    assign pkt_done = accept && mux_last;

    // Counters wrap naturally at 16'hFFFF -> 0.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gcnt0_o <= '0;
            gcnt1_o <= '0;
        end else if (pkt_done) begin
            if (select_o) begin
                gcnt1_o <= gcnt1_o + 1'b1;
            end else begin
                gcnt0_o <= gcnt0_o + 1'b1;
            end
        end
    end
`endif

endmodule : mux_rr_arbiter

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Sequencer and arbiter for a shared size-bit 2:1 mux path.
- Two requesters (src0, src1) compete for one downstream consumer. The block drives the mux select and registers the muxed beat into a one-entry output stage.
- Round-robin between packets; the grant is locked for the whole packet (until the beat flagged last).
- Sits between producer stages and a single-port consumer, e.g. a shared writeback or memory port in the datapath.

Parameters:
- size, 32, data width of each requester and of the output.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous active-low reset.
- data0_i  input  size  requester 0 beat.
- valid0_i  input  1  requester 0 beat valid.
- last0_i  input  1  requester 0 beat is the final beat of its packet.
- ready0_o  output  1  requester 0 beat accepted this cycle (when valid0_i=1).
- data1_i, valid1_i, last1_i, ready1_o: the same four signals for requester 1.
- data_o  output  size  registered output beat.
- valid_o  output  1  output beat valid.
- last_o  output  1  output beat is last of packet.
- src_o  output  1  requester index of the beat on data_o.
- ready_i  input  1  consumer accepts the output beat.
- select_o  output  1  current mux select (0 or 1); also exposed for debug.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, ptr=1 so requester 0 wins the first tie.
  - Outputs: valid_o=0, data_o=0, last_o=0, src_o=0, select_o=0, ready0_o=0, ready1_o=0.
  - Reset mid-packet abandons the packet; the output beat is discarded.
- States: IDLE, GNT0, GNT1.
- IDLE transitions:
  - Only valid0_i -> GNT0; only valid1_i -> GNT1.
  - Both valid -> GNT(~ptr).
  - Neither valid -> stay in IDLE.
  - No beat is accepted in IDLE.
- In GNTk:
  - select_o=k.
  - readyk_o = (!valid_o || ready_i); the other ready is 0.
  - Acceptance = validk_i && readyk_o.
  - On acceptance the next edge loads data_o=datak_i, last_o=lastk_i, src_o=k, valid_o=1.
  - Acceptance with lastk_i=1 -> IDLE, ptr=k. Otherwise stay in GNTk.
- Output stage:
  - valid_o && ready_i with no new acceptance -> valid_o=0 next edge.
  - Accept and drain in the same cycle -> new beat replaces old, no bubble.
  - valid_o && !ready_i -> data_o, last_o, src_o held stable and ready0_o=ready1_o=0.
- Latency:
  - Valid seen in IDLE -> grant next cycle -> beat on data_o one cycle after acceptance. Minimum 2 cycles from validk_i rising to valid_o.
  - One idle bubble between consecutive packets (return through IDLE).
- Throughput: 1 beat/cycle within a packet while ready_i=1.
- Requester deasserts valid mid-packet: the grant holds (GNTk) and waits indefinitely; the other requester is not served.
- Single-beat packets (last=1 on the first beat) are legal. Ties alternate strictly 0,1,0,1.
- select_o in IDLE keeps its previous value (no glitch toward an unselected source).

Optional Feature:
- Macro: MUX_RR_ARBITER_GRANT_CNT_EN.
- Defined:
  - Adds output ports gcnt0_o and gcnt1_o [15:0].
  - Each counts packets completed per requester (incremented on a last-beat acceptance).
  - Reset to 0; wraps 16'hFFFF -> 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (mux_arb_pkg):
  - State encoding: IDLE=2'd0, GNT0=2'd1, GNT1=2'd2.
  - Constant GCNT_W=16.
- One natural sub-module: mux_arb_out_reg, the one-entry registered output stage (load, hold, drain). The existing MUX_2_to_1 is instantiated for the data path with size=size and select_i=select_o.

Test Plan:
- Reset:
  - Stimulus: hold rst_i=0, drive valid0_i=valid1_i=1.
  - Required: all outputs 0.
  - Stimulus: release rst_i.
  - Required: first grant is GNT0; src_o=0 on the first output beat.
- Tie, round robin:
  - Stimulus: both requesters send 1-beat packets continuously (data0=32'hA0, data1=32'hB1), ready_i=1.
  - Required: src_o sequence 0,1,0,1; one bubble cycle between beats.
- Lock for burst:
  - Stimulus: src0 sends a 3-beat packet (1,2,3, last on 3); src1 is valid throughout.
  - Required: data_o 1,2,3 with src_o=0 on all three, then src1's beat.
- Backpressure:
  - Stimulus: ready_i=0 for 4 cycles with valid_o=1, data_o=32'h55.
  - Required: data_o held at 32'h55 and ready0_o=ready1_o=0; exactly one transfer after ready_i returns to 1.
- Reset mid-packet:
  - Stimulus: assert rst_i after beat 2 of 3.
  - Required: valid_o=0 immediately (asynchronously); after release, state IDLE and requester 0 is granted first.
- With MUX_RR_ARBITER_GRANT_CNT_EN:
  - Stimulus: 5 packets from src1 and 3 from src0.
  - Required: gcnt1_o=5, gcnt0_o=3.
  - Stimulus: preload near wrap, then complete one packet.
  - Required: 16'hFFFF -> 0.
